// File: rtl/pcie_rx_pkg.sv
// Shared constants, state encoding and credit helper for the PCIe RX MWr sink.
// TLP header fields arrive as 16-bit words, earlier wire byte in [15:8].
package pcie_rx_pkg;

    localparam logic [4:0] TYPE_MWR    = 5'b00000;
    localparam logic [1:0] TYPE_MSG_HI = 2'b10;
    localparam logic [4:0] TYPE_CPL    = 5'b01010;

    localparam int unsigned FMT_4DW      = 0;
    localparam int unsigned FMT_HAS_DATA = 1;

    localparam logic [3:0] HDR_WORDS_3DW  = 4'd6;
    localparam logic [3:0] HDR_WORDS_4DW  = 4'd8;
    localparam logic [9:0] MAX_PAYLOAD_DW = 10'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

    // ceil(len/4); len=0 encodes 1024 DW, so the result saturates at 255
    function automatic logic [7:0] pd_credits(input logic [9:0] len);
        logic [10:0] sum;
        sum = {1'b0, len} + 11'd3;
        if (len == 10'd0) begin
            pd_credits = 8'd255;
        end else if (sum[10:2] > 9'd255) begin
            pd_credits = 8'd255;
        end else begin
            pd_credits = sum[9:2];
        end
    endfunction

endpackage

// File: rtl/pcie_rx_credit_ret.sv
// Classifies a finished TLP and emits one-cycle credit release pulses
// in the cycle after the done strobe.
module pcie_rx_credit_ret
    import pcie_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] fmt,
    input  logic [4:0] tlp_type,
    input  logic [9:0] len,
    input  logic       done,
    output logic       ph_processed,
    output logic       pd_processed,
    output logic [7:0] pd_num,
    output logic       nph_processed,
    output logic       npd_processed
);

    logic       posted_s;
    logic       cpl_s;
    logic       has_data_s;
    logic       unused_fmt_s;
    logic       ph_r;
    logic       pd_r;
    logic [7:0] pd_num_r;
    logic       nph_r;
    logic       npd_r;

    assign posted_s     = (fmt[FMT_HAS_DATA] && (tlp_type == TYPE_MWR)) || (tlp_type[4:3] == TYPE_MSG_HI);
    assign cpl_s        = (tlp_type == TYPE_CPL);
    assign has_data_s   = fmt[FMT_HAS_DATA];
    assign unused_fmt_s = fmt[FMT_4DW];

    // Registered credit pulses; completions never consume receiver credit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ph_r     <= 1'b0;
            pd_r     <= 1'b0;
            pd_num_r <= 8'd0;
            nph_r    <= 1'b0;
            npd_r    <= 1'b0;
        end else begin
            ph_r     <= done && posted_s;
            pd_r     <= done && posted_s && has_data_s;
            pd_num_r <= (done && posted_s && has_data_s) ? pd_credits(len) : 8'd0;
            nph_r    <= done && !posted_s && !cpl_s;
            npd_r    <= done && !posted_s && !cpl_s && has_data_s;
        end
    end

    assign ph_processed  = ph_r;
    assign pd_processed  = pd_r;
    assign pd_num        = pd_num_r;
    assign nph_processed = nph_r;
    assign npd_processed = npd_r;

endmodule

// File: rtl/pcie_rx_mwr_sink.sv
// Receives 16-bit TLP words, writes a single-byte LED register on a claimed
// MWr, returns flow-control credits and flags malformed or truncated TLPs.
module pcie_rx_mwr_sink
    import pcie_rx_pkg::*;
#(
    parameter int unsigned BAR_SEL    = 0,
    parameter logic [11:0] LED_OFFSET = 12'h000,
    parameter logic [7:0]  LED_RESET  = 8'hFE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] rx_data,
    input  logic        rx_st,
    input  logic        rx_end,
    input  logic [6:0]  rx_bar_hit,
    output logic [7:0]  led_out,
    output logic        wr_strobe,
    output logic        ph_processed,
    output logic        pd_processed,
    output logic [7:0]  pd_num,
    output logic        nph_processed,
    output logic        npd_processed,
    output logic        err,
    output logic [7:0]  drop_cnt
);

    rx_state_e   state_r, state_n_s;
    logic [3:0]  idx_r;
    logic [1:0]  fmt_r;
    logic [4:0]  type_r;
    logic        bar_r;
    logic [9:0]  len_r;
    logic        be0_r;
    logic        off_ok_r;
    logic [7:0]  data_r;
    logic        have_data_r;
    logic [7:0]  led_r;
    logic        wr_strobe_r;
    logic        err_r;
    logic [7:0]  drop_cnt_r;

    logic [3:0]  hdr_last_s;
    logic        off_match_s;
    logic        off_ok_s;
    logic        claim_s;
    logic        commit_s;
    logic [7:0]  led_byte_s;
    logic        len_bad_s;
    logic        done_s;
    logic        trunc_s;
    logic        abandon_s;
    logic        unused_bar_s;

    assign hdr_last_s   = fmt_r[FMT_4DW] ? (HDR_WORDS_4DW - 4'd1) : (HDR_WORDS_3DW - 4'd1);
    assign off_match_s  = (rx_data[11:2] == LED_OFFSET[11:2]);
    // A TLP may end on its last header word, before the offset has been latched
    assign off_ok_s     = (state_r == ST_HDR) ? off_match_s : off_ok_r;
    assign claim_s      = fmt_r[FMT_HAS_DATA] && (type_r == TYPE_MWR) && bar_r && off_ok_s
                          && (len_r == 10'd1) && be0_r;
    assign led_byte_s   = have_data_r ? data_r : rx_data[15:8];
    assign len_bad_s    = fmt_r[FMT_HAS_DATA] && ((len_r == 10'd0) || (len_r > MAX_PAYLOAD_DW));
    assign unused_bar_s = ^rx_bar_hit;

    // Next-state and TLP boundary events; rx_st always restarts header parsing
    always_comb begin
        state_n_s = state_r;
        done_s    = 1'b0;
        trunc_s   = 1'b0;
        abandon_s = 1'b0;
        if (rx_st) begin
            abandon_s = (state_r != ST_IDLE);
            if (rx_end) begin
                trunc_s   = 1'b1;
                state_n_s = ST_IDLE;
            end else begin
                state_n_s = ST_HDR;
            end
        end else begin
            case (state_r)
                ST_IDLE: state_n_s = ST_IDLE;
                ST_HDR: begin
                    if (idx_r == hdr_last_s) begin
                        if (rx_end) begin
                            done_s    = 1'b1;
                            state_n_s = ST_IDLE;
                        end else if (fmt_r[FMT_HAS_DATA]) begin
                            state_n_s = ST_DATA;
                        end else begin
                            state_n_s = ST_DROP;
                        end
                    end else if (rx_end) begin
                        trunc_s   = 1'b1;
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_HDR;
                    end
                end
                ST_DATA, ST_DROP: begin
                    if (rx_end) begin
                        done_s    = 1'b1;
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = state_r;
                    end
                end
                default: state_n_s = ST_IDLE;
            endcase
        end
    end

    assign commit_s = done_s && claim_s && (state_r == ST_DATA);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Header field capture; idx_r holds the index of the word currently on rx_data
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx_r       <= 4'd0;
            fmt_r       <= 2'd0;
            type_r      <= 5'd0;
            bar_r       <= 1'b0;
            len_r       <= 10'd0;
            be0_r       <= 1'b0;
            off_ok_r    <= 1'b0;
            data_r      <= 8'd0;
            have_data_r <= 1'b0;
        end else if (rx_st) begin
            idx_r       <= 4'd1;
            fmt_r       <= rx_data[14:13];
            type_r      <= rx_data[12:8];
            bar_r       <= rx_bar_hit[BAR_SEL];
            len_r       <= 10'd0;
            be0_r       <= 1'b0;
            off_ok_r    <= 1'b0;
            have_data_r <= 1'b0;
        end else if (state_r == ST_HDR) begin
            idx_r <= idx_r + 4'd1;
            if (idx_r == 4'd1) len_r <= rx_data[9:0];
            if (idx_r == 4'd3) be0_r <= rx_data[0];
            if (idx_r == hdr_last_s) off_ok_r <= off_match_s;
        end else if ((state_r == ST_DATA) && !have_data_r) begin
            data_r      <= rx_data[15:8];
            have_data_r <= 1'b1;
        end
    end

    // LED register, write strobe, error pulse and drop counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            led_r       <= LED_RESET;
            wr_strobe_r <= 1'b0;
            err_r       <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            wr_strobe_r <= commit_s;
            if (commit_s) led_r <= led_byte_s;
            err_r <= trunc_s || abandon_s || (done_s && len_bad_s);
            if (done_s && !claim_s && (drop_cnt_r != 8'd255)) drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    pcie_rx_credit_ret u_credit (
        .clk           (clk),
        .rstn          (rstn),
        .fmt           (fmt_r),
        .tlp_type      (type_r),
        .len           (len_r),
        .done          (done_s),
        .ph_processed  (ph_processed),
        .pd_processed  (pd_processed),
        .pd_num        (pd_num),
        .nph_processed (nph_processed),
        .npd_processed (npd_processed)
    );

    assign led_out   = led_r;
    assign wr_strobe = wr_strobe_r;
    assign err       = err_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pcie_rx_mwr_sink.sv
// Directed bench for pcie_rx_mwr_sink: each task drives TLP word sequences and
// checks LED, credit pulses, err and drop_cnt against hand-computed values.
module tb_pcie_rx_mwr_sink;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] rx_data;
    logic        rx_st;
    logic        rx_end;
    logic [6:0]  rx_bar_hit;
    logic [7:0]  led_out;
    logic        wr_strobe;
    logic        ph_processed;
    logic        pd_processed;
    logic [7:0]  pd_num;
    logic        nph_processed;
    logic        npd_processed;
    logic        err;
    logic [7:0]  drop_cnt;
    logic [5:0]  pulses;

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;
    int n;
    int hl;
    logic [15:0] tw [0:31];

    always #5 clk = ~clk;

    // {wr_strobe, ph, pd, nph, npd, err}
    assign pulses = {wr_strobe, ph_processed, pd_processed, nph_processed, npd_processed, err};

    pcie_rx_mwr_sink dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_st(rx_st), .rx_end(rx_end),
        .rx_bar_hit(rx_bar_hit), .led_out(led_out), .wr_strobe(wr_strobe),
        .ph_processed(ph_processed), .pd_processed(pd_processed), .pd_num(pd_num),
        .nph_processed(nph_processed), .npd_processed(npd_processed), .err(err),
        .drop_cnt(drop_cnt)
    );

    task automatic drive(input logic [15:0] d, input logic st, input logic en, input logic [6:0] bar);
        @(negedge clk);
        rx_data = d; rx_st = st; rx_end = en; rx_bar_hit = bar;
    endtask

    // Returns at the negedge of the cycle after rx_end
    task automatic send(input int cnt, input logic [6:0] bar);
        for (int i = 0; i < cnt; i++) drive(tw[i], (i == 0), (i == cnt - 1), bar);
        drive(16'h0000, 1'b0, 1'b0, 7'd0);
    endtask

    task automatic mk_hdr(input logic [15:0] w0, input logic [9:0] len, input logic [15:0] alo,
                          input bit dw4, output int hlen);
        tw[0] = w0; tw[1] = {6'd0, len}; tw[2] = 16'h0100; tw[3] = 16'h0201;
        if (dw4) begin
            tw[4] = 16'h0000; tw[5] = 16'h0000; tw[6] = 16'hF0F4; tw[7] = alo; hlen = 8;
        end else begin
            tw[4] = 16'hF0F4; tw[5] = alo; hlen = 6;
        end
    endtask

    task automatic mk_mwr(input logic [9:0] len, input logic [7:0] d, input int ndata, output int cnt);
        int h;
        mk_hdr(16'h4000, len, 16'h0000, 1'b0, h);
        tw[h] = {d, 8'h00};
        for (int i = 1; i < ndata; i++) tw[h + i] = 16'h5A5A;
        cnt = h + ndata;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx_data = 16'h0; rx_st = 1'b0; rx_end = 1'b0; rx_bar_hit = 7'd0;
        repeat (3) @(negedge clk);
        total++; if (led_out !== 8'hFE) begin bad++; $display("FAIL reset_led got=%h exp=fe", led_out); end
        total++; if (pulses !== 6'b000000) begin bad++; $display("FAIL reset_pulses got=%b exp=000000", pulses); end
        total++; if (pd_num !== 8'd0) begin bad++; $display("FAIL reset_pd_num got=%0d exp=0", pd_num); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        rstn = 1'b1;
        @(negedge clk);
        total++; if (led_out !== 8'hFE) begin bad++; $display("FAIL reset_hold_led got=%h exp=fe", led_out); end
    endtask

    task automatic test_mwr_claim();
        mk_mwr(10'd1, 8'hA5, 2, n);
        send(n, 7'b0000001);
        total++; if (led_out !== 8'hA5) begin bad++; $display("FAIL claim_led got=%h exp=a5", led_out); end
        total++; if (pulses !== 6'b111000) begin bad++; $display("FAIL claim_pulses got=%b exp=111000", pulses); end
        total++; if (pd_num !== 8'd1) begin bad++; $display("FAIL claim_pd_num got=%0d exp=1", pd_num); end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL claim_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        @(negedge clk);
        total++; if (pulses !== 6'b000000) begin bad++; $display("FAIL claim_one_cycle got=%b exp=000000", pulses); end
    endtask

    task automatic test_bar_miss();
        mk_mwr(10'd1, 8'h11, 2, n);
        send(n, 7'b0000010);
        exp_drop++;
        total++; if (led_out !== 8'hA5) begin bad++; $display("FAIL miss_led got=%h exp=a5", led_out); end
        total++; if (pulses !== 6'b011000) begin bad++; $display("FAIL miss_pulses got=%b exp=011000", pulses); end
        total++; if (pd_num !== 8'd1) begin bad++; $display("FAIL miss_pd_num got=%0d exp=1", pd_num); end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL miss_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_mrd_4dw();
        mk_hdr(16'h2000, 10'd4, 16'h0000, 1'b1, hl);
        send(hl, 7'b0000001);
        exp_drop++;
        total++; if (pulses !== 6'b000100) begin bad++; $display("FAIL mrd_pulses got=%b exp=000100", pulses); end
        total++; if (pd_num !== 8'd0) begin bad++; $display("FAIL mrd_pd_num got=%0d exp=0", pd_num); end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL mrd_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_pd_num();
        mk_mwr(10'd9, 8'h22, 18, n);
        send(n, 7'b0000001);
        exp_drop++;
        total++; if (pd_num !== 8'd3) begin bad++; $display("FAIL len9_pd_num got=%0d exp=3", pd_num); end
        total++; if (pulses !== 6'b011000) begin bad++; $display("FAIL len9_pulses got=%b exp=011000", pulses); end
        total++; if (led_out !== 8'hA5) begin bad++; $display("FAIL len9_led got=%h exp=a5", led_out); end
        mk_mwr(10'd33, 8'h33, 2, n);
        send(n, 7'b0000001);
        exp_drop++;
        total++; if (pd_num !== 8'd9) begin bad++; $display("FAIL len33_pd_num got=%0d exp=9", pd_num); end
        total++; if (pulses !== 6'b011001) begin bad++; $display("FAIL len33_pulses got=%b exp=011001", pulses); end
        mk_mwr(10'd0, 8'h44, 2, n);
        send(n, 7'b0000001);
        exp_drop++;
        total++; if (pd_num !== 8'd255) begin bad++; $display("FAIL len0_pd_num got=%0d exp=255", pd_num); end
        total++; if (pulses !== 6'b011001) begin bad++; $display("FAIL len0_pulses got=%b exp=011001", pulses); end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL len_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_msg_cpl();
        mk_hdr(16'h3000, 10'd0, 16'h0000, 1'b1, hl);
        send(hl, 7'b0000001);
        exp_drop++;
        total++; if (pulses !== 6'b010000) begin bad++; $display("FAIL msg_pulses got=%b exp=010000", pulses); end
        mk_hdr(16'h4A00, 10'd1, 16'h0000, 1'b0, hl);
        tw[6] = 16'h1100; tw[7] = 16'h0000;
        send(8, 7'b0000001);
        exp_drop++;
        total++; if (pulses !== 6'b000000) begin bad++; $display("FAIL cpl_pulses got=%b exp=000000", pulses); end
        total++; if (led_out !== 8'hA5) begin bad++; $display("FAIL cpl_led got=%h exp=a5", led_out); end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL cpl_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_truncated();
        mk_mwr(10'd1, 8'h99, 2, n);
        send(4, 7'b0000001);
        total++; if (pulses !== 6'b000001) begin bad++; $display("FAIL trunc_pulses got=%b exp=000001", pulses); end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL trunc_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        send(1, 7'b0000001);
        total++; if (pulses !== 6'b000001) begin bad++; $display("FAIL one_word_pulses got=%b exp=000001", pulses); end
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL trunc_err_clear got=%b exp=0", err); end
        total++; if (led_out !== 8'hA5) begin bad++; $display("FAIL trunc_led got=%h exp=a5", led_out); end
    endtask

    task automatic test_back_to_back();
        mk_mwr(10'd1, 8'h3C, 2, n);
        for (int i = 0; i < 3; i++) drive(tw[i], (i == 0), 1'b0, 7'b0000001);
        for (int i = 0; i < n; i++) begin
            drive(tw[i], (i == 0), (i == n - 1), 7'b0000001);
            if (i == 1) begin
                total++; if (pulses !== 6'b000001) begin bad++; $display("FAIL abandon_err got=%b exp=000001", pulses); end
            end
            if (i == 2) begin
                total++; if (pulses !== 6'b000000) begin bad++; $display("FAIL abandon_err_one got=%b exp=000000", pulses); end
            end
        end
        drive(16'h0000, 1'b0, 1'b0, 7'd0);
        total++; if (led_out !== 8'h3C) begin bad++; $display("FAIL b2b_led got=%h exp=3c", led_out); end
        total++; if (pulses !== 6'b111000) begin bad++; $display("FAIL b2b_pulses got=%b exp=111000", pulses); end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_drop_sat();
        mk_mwr(10'd1, 8'h00, 2, n);
        for (int k = 0; k < 250; k++) begin
            send(n, 7'b0000010);
            if (exp_drop < 255) exp_drop++;
        end
        total++; if (drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL drop_sat got=%0d exp=%0d", drop_cnt, exp_drop); end
        total++; if (led_out !== 8'h3C) begin bad++; $display("FAIL drop_sat_led got=%h exp=3c", led_out); end
    endtask

    task automatic test_reset_mid_data();
        mk_mwr(10'd1, 8'h77, 2, n);
        for (int i = 0; i < 7; i++) drive(tw[i], (i == 0), 1'b0, 7'b0000001);
        @(negedge clk);
        rstn = 1'b0; rx_data = 16'h0; rx_st = 1'b0; rx_end = 1'b0; rx_bar_hit = 7'd0;
        @(negedge clk);
        rstn = 1'b1;
        exp_drop = 0;
        total++; if (led_out !== 8'hFE) begin bad++; $display("FAIL rst_mid_led got=%h exp=fe", led_out); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_drop got=%0d exp=0", drop_cnt); end
        drive(tw[7], 1'b0, 1'b1, 7'b0000001);
        drive(16'h0000, 1'b0, 1'b0, 7'd0);
        total++; if (pulses !== 6'b000000) begin bad++; $display("FAIL rst_mid_pulses got=%b exp=000000", pulses); end
        total++; if (led_out !== 8'hFE) begin bad++; $display("FAIL rst_mid_led_after got=%h exp=fe", led_out); end
    endtask

    initial begin
        test_reset();
        test_mwr_claim();
        test_bar_miss();
        test_mrd_4dw();
        test_pd_num();
        test_msg_cpl();
        test_truncated();
        test_back_to_back();
        test_drop_sat();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
